// File: rtl/avalon_burst_agent_if.sv
// Avalon-MM host/agent signal bundle for avalon_burst_agent.
// master = host side, slave = memory agent side.
interface avalon_burst_agent_if #(
    parameter int DATA_W  = 32,
    parameter int BURST_W = 6
);
    logic [31:0]         address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [BURST_W-1:0]  burstcount;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                protocol_err;

    modport master (
        output address, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid, protocol_err
    );

    modport slave (
        input  address, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid, protocol_err
    );
endinterface

// File: rtl/avalon_burst_agent.sv
// Avalon-MM burst agent: on-chip word memory serving one read or write burst at a time.
// Read beats leave RD_LATENCY cycles after acceptance, back-to-back; writes honour byteenable.
module avalon_burst_agent #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int BURST_W    = 6,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    avalon_burst_agent_if.slave av
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [BURST_W-1:0]  left_q, left_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                rdv_q, rdv_d;
    logic                rd_last_q, rd_last_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   addr_idx;
    logic [BURST_W-1:0]  n_eff;
    logic                iss_vld, iss_last;
    logic [ADDR_W-1:0]   iss_idx;
    logic                tail_vld, tail_last;
    logic [ADDR_W-1:0]   tail_idx;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;
    logic                unused_addr;

    assign addr_idx    = av.address[ADDR_W+1:2];
    assign unused_addr = ^{av.address[31:ADDR_W+2], av.address[1:0]};
    assign n_eff       = (av.burstcount == '0) ? BURST_W'(1) : av.burstcount;
    assign ready_d     = 1'b1;

    // ready_q keeps waitrequest high while in reset and for the release edge
    assign av.waitrequest   = !ready_q || (state_q == RD_BURST);
    assign av.readdata      = readdata_q;
    assign av.readdatavalid = rdv_q;
    assign av.protocol_err  = err_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        left_d   = left_q;
        err_d    = err_q;
        iss_vld  = 1'b0;
        iss_idx  = ptr_q;
        iss_last = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = ptr_q;
        case (state_q)
            IDLE: begin
                if (ready_q && av.read) begin
                    iss_vld  = 1'b1;
                    iss_idx  = addr_idx;
                    iss_last = (n_eff == BURST_W'(1));
                    ptr_d    = addr_idx + ADDR_W'(1);
                    left_d   = n_eff - BURST_W'(1);
                    state_d  = RD_BURST;
                    if (av.write) err_d = 1'b1;
                end else if (ready_q && av.write) begin
                    wr_en  = 1'b1;
                    wr_idx = addr_idx;
                    ptr_d  = addr_idx + ADDR_W'(1);
                    left_d = n_eff - BURST_W'(1);
                    if (n_eff != BURST_W'(1)) state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                if (left_q != '0) begin
                    iss_vld  = 1'b1;
                    iss_last = (left_q == BURST_W'(1));
                    ptr_d    = ptr_q + ADDR_W'(1);
                    left_d   = left_q - BURST_W'(1);
                end
                // the final beat on the bus releases the agent for the next command
                if (rdv_q && rd_last_q) state_d = IDLE;
            end
            WR_BURST: begin
                if (av.read) err_d = 1'b1;
                if (av.write) begin
                    wr_en  = 1'b1;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    left_d = left_q - BURST_W'(1);
                    if (left_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign tail_vld  = iss_vld;
            assign tail_idx  = iss_idx;
            assign tail_last = iss_last;
        end else begin : g_pipe
            logic              pipe_vld_q  [RD_LATENCY-1];
            logic              pipe_last_q [RD_LATENCY-1];
            logic [ADDR_W-1:0] pipe_idx_q  [RD_LATENCY-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pipe_vld_q[i]  <= 1'b0;
                        pipe_last_q[i] <= 1'b0;
                        pipe_idx_q[i]  <= '0;
                    end
                end else begin
                    pipe_vld_q[0]  <= iss_vld;
                    pipe_last_q[0] <= iss_last;
                    pipe_idx_q[0]  <= iss_idx;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipe_vld_q[i]  <= pipe_vld_q[i-1];
                        pipe_last_q[i] <= pipe_last_q[i-1];
                        pipe_idx_q[i]  <= pipe_idx_q[i-1];
                    end
                end
            end

            assign tail_vld  = pipe_vld_q[RD_LATENCY-2];
            assign tail_idx  = pipe_idx_q[RD_LATENCY-2];
            assign tail_last = pipe_last_q[RD_LATENCY-2];
        end
    endgenerate

    // memory is read at the last stage so a just-finished write is always visible
    always_comb begin
        rdv_d      = tail_vld;
        rd_last_d  = tail_vld && tail_last;
        readdata_d = tail_vld ? mem[tail_idx] : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            left_q     <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdv_q      <= 1'b0;
            rd_last_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            left_q     <= left_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            rdv_q      <= rdv_d;
            rd_last_q  <= rd_last_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (av.byteenable[b]) mem[wr_idx][8*b +: 8] <= av.writedata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_avalon_burst_agent.sv
// Directed bench for avalon_burst_agent: bursts, byte lanes, wrap, errors, reset abort, held reads.
module tb_avalon_burst_agent;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] wbuf [16];
    logic [31:0] ebuf [16];

    avalon_burst_agent_if #(.DATA_W(32), .BURST_W(6)) av ();

    avalon_burst_agent #(
        .ADDR_W(10), .DATA_W(32), .BURST_W(6), .RD_LATENCY(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .av(av)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        av.read = 1'b0;
        av.write = 1'b0;
        av.address = '0;
        av.writedata = '0;
        av.byteenable = '0;
        av.burstcount = '0;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int n, input logic [3:0] be);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            av.write = 1'b1;
            av.address = addr;
            av.burstcount = 6'(n);
            av.writedata = wbuf[k];
            av.byteenable = be;
        end
        @(negedge clk);
        bus_idle();
    endtask

    // command at cycle T; beats expected at T+2..T+n+1, waitrequest low again at T+n+2
    task automatic rd_burst(input string tag, input logic [31:0] addr, input int n);
        @(negedge clk);
        check_eq({tag, "_acc_wait"}, 32'(av.waitrequest), 32'd0);
        av.read = 1'b1;
        av.address = addr;
        av.burstcount = 6'(n);
        for (int j = 1; j <= n + 2; j++) begin
            @(negedge clk);
            if (j == 1) bus_idle();
            check_eq($sformatf("%s_rdv_%0d", tag, j), 32'(av.readdatavalid),
                     32'((j >= 2) && (j <= n + 1)));
            if (j >= 2 && j <= n + 1)
                check_eq($sformatf("%s_data_%0d", tag, j - 2), av.readdata, ebuf[j-2]);
        end
        check_eq({tag, "_wait_end"}, 32'(av.waitrequest), 32'd0);
    endtask

    int acc;
    int beats;
    int acc_cyc [2];
    logic drop;

    initial begin
        bus_idle();
        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst_wait", 32'(av.waitrequest), 32'd1);
        check_eq("rst_rdv", 32'(av.readdatavalid), 32'd0);
        check_eq("rst_rdata", av.readdata, 32'd0);
        check_eq("rst_err", 32'(av.protocol_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rel_wait", 32'(av.waitrequest), 32'd0);

        // 1: write burst then read burst with exact latency
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = 32'hA5A5_00A0 + 32'(k);
            ebuf[k] = 32'hA5A5_00A0 + 32'(k);
        end
        wr_burst(32'h100, 4, 4'hF);
        rd_burst("t1", 32'h100, 4);

        // 2: byte lanes
        wbuf[0] = 32'h1122_3344;
        wr_burst(32'h20, 1, 4'hF);
        wbuf[0] = 32'hAABB_CCDD;
        wr_burst(32'h20, 1, 4'b0101);
        ebuf[0] = 32'h11BB_33DD;
        rd_burst("t2", 32'h20, 1);

        // 3: wrap at end of memory
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = 32'h3000_0000 + 32'(k);
            ebuf[k] = 32'h3000_0000 + 32'(k);
        end
        wr_burst(32'hFF8, 4, 4'hF);
        rd_burst("t3_wrap", 32'hFF8, 4);
        ebuf[0] = 32'h3000_0002;
        ebuf[1] = 32'h3000_0003;
        rd_burst("t3_low", 32'h0, 2);

        // 4: read and write together in IDLE
        wbuf[0] = 32'h4444_0000;
        wr_burst(32'h40, 1, 4'hF);
        @(negedge clk);
        av.read = 1'b1;
        av.write = 1'b1;
        av.address = 32'h40;
        av.burstcount = 6'd1;
        av.writedata = 32'hBADB_AD00;
        av.byteenable = 4'hF;
        @(negedge clk);
        bus_idle();
        check_eq("t4_err", 32'(av.protocol_err), 32'd1);
        @(negedge clk);
        check_eq("t4_rdv", 32'(av.readdatavalid), 32'd1);
        check_eq("t4_data", av.readdata, 32'h4444_0000);
        @(negedge clk);
        ebuf[0] = 32'h4444_0000;
        rd_burst("t4_mem", 32'h40, 1);
        check_eq("t4_err_sticky", 32'(av.protocol_err), 32'd1);

        // 5: reset in the middle of an N=16 read
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h5000_0000 + 32'(k);
        wr_burst(32'h600, 16, 4'hF);
        @(negedge clk);
        av.read = 1'b1;
        av.address = 32'h600;
        av.burstcount = 6'd16;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        check_eq("t5_b0", av.readdata, 32'h5000_0000);
        @(negedge clk);
        check_eq("t5_b1", av.readdata, 32'h5000_0001);
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_rdv", 32'(av.readdatavalid), 32'd0);
        check_eq("t5_rst_wait", 32'(av.waitrequest), 32'd1);
        check_eq("t5_rst_err", 32'(av.protocol_err), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("t5_hold_wait", 32'(av.waitrequest), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("t5_rel_wait", 32'(av.waitrequest), 32'd0);
        check_eq("t5_rel_rdv", 32'(av.readdatavalid), 32'd0);
        ebuf[0] = 32'h5000_0000;
        ebuf[1] = 32'h5000_0001;
        ebuf[2] = 32'h5000_0002;
        rd_burst("t5_mem", 32'h600, 3);

        // 6a: write burst with idle gaps, plus a read during WR_BURST
        @(negedge clk);
        av.write = 1'b1;
        av.address = 32'h300;
        av.burstcount = 6'd3;
        av.byteenable = 4'hF;
        av.writedata = 32'hC0DE_0000;
        @(negedge clk);
        av.write = 1'b0;
        av.read = 1'b1;
        av.writedata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("t6_wr_rd_err", 32'(av.protocol_err), 32'd1);
        av.read = 1'b0;
        av.write = 1'b1;
        av.writedata = 32'hC0DE_0001;
        @(negedge clk);
        av.write = 1'b0;
        av.writedata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        av.write = 1'b1;
        av.writedata = 32'hC0DE_0002;
        @(negedge clk);
        bus_idle();
        for (int k = 0; k < 3; k++) ebuf[k] = 32'hC0DE_0000 + 32'(k);
        rd_burst("t6_gap", 32'h300, 3);

        // 6b: host holds read=1 with N=16 across waitrequest
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h6000_0000 + 32'(k);
        wr_burst(32'h400, 16, 4'hF);
        acc = 0;
        beats = 0;
        drop = 1'b0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                av.read = 1'b1;
                av.address = 32'h400;
                av.burstcount = 6'd16;
            end
            if (drop) av.read = 1'b0;
            if (av.readdatavalid) begin
                if (beats < 32) begin
                    check_eq($sformatf("t6_hold_cyc_%0d", beats), 32'(cyc),
                             32'(acc_cyc[beats/16] + 2 + beats % 16));
                    check_eq($sformatf("t6_hold_data_%0d", beats), av.readdata,
                             32'h6000_0000 + 32'(beats % 16));
                end
                beats++;
            end
            if (av.read && !av.waitrequest) begin
                if (acc < 2) acc_cyc[acc] = cyc;
                acc++;
                if (acc == 2) drop = 1'b1;
            end
        end
        bus_idle();
        check_eq("t6_hold_acc", 32'(acc), 32'd2);
        check_eq("t6_hold_beats", 32'(beats), 32'd32);
        check_eq("t6_hold_reacc", 32'(acc_cyc[1]), 32'(acc_cyc[0] + 18));
        check_eq("t6_err_sticky", 32'(av.protocol_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
